// File: rtl/lsu_datamemory.sv
// Handshaked byte-enabled load/store data memory with sign/zero-extending loads.
// Define DM_MISALIGN_SPLIT_EN to run misaligned accesses as two word beats.
module lsu_datamemory #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  fault
);

  localparam int WI    = DM_ADDRESS - 2;
  localparam int DEPTH = 1 << WI;

  if (DATA_W != 32) begin : g_bad_width
    $error("lsu_datamemory supports DATA_W=32 only");
  end

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          noop;
  logic          conflict;
  logic          illegal;
  logic          misal;
  logic          fault_req;
  logic          st_ok;
  logic          ld_ok;
  logic [1:0]    off;
  logic [WI-1:0] w;
  logic [3:0]    m4;
  logic [7:0]    mask8;
  logic [4:0]    lane_sh;
  logic [31:0]   wd_lo;

  logic [WI-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          rsp_valid_q, rsp_valid_d;
  logic          fault_q, fault_d;
  logic [31:0]   rd_q, rd_d;

`ifdef DM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, BEAT2} state_e;

  state_e        state_q, state_d;
  logic [WI-1:0] w1;
  logic [31:0]   wd_hi;
  logic [WI-1:0] w1_q, w1_d;
  logic [31:0]   buf_q, buf_d;
  logic [3:0]    hi_be_q, hi_be_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;

  localparam bit SPLIT = 1'b1;

  assign req_ready = (state_q == IDLE);
  assign w1        = w + 1'b1;
  assign wd_hi     = (off == 2'd0) ? 32'h0 : wd >> (6'd32 - {1'b0, lane_sh});
`else
  localparam bit SPLIT = 1'b0;

  assign req_ready = 1'b1;
`endif

  assign rsp_valid = rsp_valid_q;
  assign fault     = fault_q;
  assign rd        = rd_q;
  assign mem_rdata = mem[mem_idx];

  function automatic logic [31:0] load_ext(
    input logic [63:0] win,
    input logic [1:0]  o,
    input logic [2:0]  f3
  );
    logic [31:0] s;
    logic [31:0] r;
    s = 32'(win >> {o, 3'b000});
    case (f3[1:0])
      2'b00:   r = {{24{s[7] & ~f3[2]}}, s[7:0]};
      2'b01:   r = {{16{s[15] & ~f3[2]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    accept   = req_valid && req_ready;
    off      = a[1:0];
    w        = a[DM_ADDRESS-1:2];
    lane_sh  = {off, 3'b000};
    noop     = !MemRead && !MemWrite;
    conflict = MemRead && MemWrite;
    illegal  = (Funct3[1:0] == 2'b11)
             || (Funct3[2] && (MemWrite || Funct3[1]));
    case (Funct3[1:0])
      2'b00:   m4 = 4'b0001;
      2'b01:   m4 = 4'b0011;
      default: m4 = 4'b1111;
    endcase
    mask8     = {4'b0000, m4} << off;
    misal     = |mask8[7:4];
    fault_req = !noop && (conflict || illegal || (misal && !SPLIT));
    st_ok     = !fault_req && MemWrite;
    ld_ok     = !fault_req && MemRead;
    wd_lo     = wd << lane_sh;
  end

  always_comb begin
    rsp_valid_d = 1'b0;
    fault_d     = 1'b0;
    rd_d        = rd_q;
    mem_idx     = w;
    mem_be      = 4'b0000;
    mem_wdata   = wd_lo;
`ifdef DM_MISALIGN_SPLIT_EN
    state_d = state_q;
    w1_d    = w1_q;
    buf_d   = buf_q;
    hi_be_d = hi_be_q;
    is_wr_d = is_wr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    if (state_q == BEAT2) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      mem_idx     = w1_q;
      if (is_wr_q) begin
        mem_be    = hi_be_q;
        mem_wdata = buf_q;
      end else begin
        rd_d = load_ext({mem_rdata, buf_q}, off_q, f3_q);
      end
    end else
`endif
    if (accept) begin
      rsp_valid_d = 1'b1;
      unique case (1'b1)
        fault_req: begin
          fault_d = 1'b1;
          if (MemRead) rd_d = '0;
        end
        st_ok: begin
          mem_be = mask8[3:0];
`ifdef DM_MISALIGN_SPLIT_EN
          if (misal) begin
            rsp_valid_d = 1'b0;
            state_d     = BEAT2;
            w1_d        = w1;
            buf_d       = wd_hi;
            hi_be_d     = mask8[7:4];
            is_wr_d     = 1'b1;
          end
`endif
        end
        ld_ok: begin
          rd_d = load_ext({32'h0, mem_rdata}, off, Funct3);
`ifdef DM_MISALIGN_SPLIT_EN
          if (misal) begin
            rd_d        = rd_q;
            rsp_valid_d = 1'b0;
            state_d     = BEAT2;
            w1_d        = w1;
            buf_d       = mem_rdata;
            is_wr_d     = 1'b0;
            off_d       = off;
            f3_d        = Funct3;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // A write is dropped while reset is held so an abandoned beat never lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i] && rst_n) begin
        mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rd_q        <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
      rd_q        <= rd_d;
    end
  end

`ifdef DM_MISALIGN_SPLIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w1_q    <= '0;
      buf_q   <= '0;
      hi_be_q <= '0;
      is_wr_q <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      w1_q    <= w1_d;
      buf_q   <= buf_d;
      hi_be_q <= hi_be_d;
      is_wr_q <= is_wr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_datamemory.sv
// Bench for lsu_datamemory: directed plan steps plus random traffic
// checked against a byte-array reference model.
module tb_lsu_datamemory;

`ifdef DM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [8:0]  a = '0;
  logic [31:0] wd = '0;
  logic [2:0]  Funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rd;
  logic        fault;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mm [512];
  logic [31:0] exp_rd = '0;

  lsu_datamemory #(
    .DM_ADDRESS(9),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .a(a),
    .wd(wd),
    .Funct3(Funct3),
    .rsp_valid(rsp_valid),
    .rd(rd),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int idx(input logic [8:0] ad, input int i);
    return (int'(ad) + i) % 512;
  endfunction

  // Issue one request from a negedge; return at the negedge showing its response.
  task automatic send(input bit mr, input bit mw, input logic [2:0] f3,
                      input logic [8:0] ad, input logic [31:0] d,
                      input string tag);
    int sz;
    bit nop, ill, mis, flt, two;
    logic [31:0] v;
    nop = !mr && !mw;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (mw && !mr) ill = !(f3 inside {3'd0, 3'd1, 3'd2});
    else           ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (int'(ad[1:0]) + sz) > 4;
    flt = !nop && ((mr && mw) || ill || (mis && !SPLIT));
    two = !flt && !nop && mis;
    req_valid = 1'b1;
    MemRead   = mr;
    MemWrite  = mw;
    Funct3    = f3;
    a         = ad;
    wd        = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    if (flt) begin
      if (mr) exp_rd = '0;
    end else if (mw) begin
      for (int i = 0; i < sz; i++) mm[idx(ad, i)] = d[8*i +: 8];
    end else if (mr) begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[idx(ad, i)];
      if (sz == 1) v = {{24{v[7] & ~f3[2]}}, v[7:0]};
      if (sz == 2) v = {{16{v[15] & ~f3[2]}}, v[15:0]};
      exp_rd = v;
    end
    if (two) begin
      chk({tag, "_b2_ready"}, req_ready, 32'd0);
      chk({tag, "_b2_rv"}, rsp_valid, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_rv"}, rsp_valid, 32'd1);
    chk({tag, "_fault"}, fault, 32'(flt));
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_ready"}, req_ready, 32'd1);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_rv"}, rsp_valid, 32'd0);
  endtask

  initial begin
    int r;
    bit mr, mw;
    logic [2:0] f3;

    @(negedge clk);
    @(negedge clk);
    chk("rst_rv", rsp_valid, 32'd0);
    chk("rst_fault", fault, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_ready", req_ready, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 128; i++) send(0, 1, 3'b010, 9'(i * 4), $urandom, "init");

    send(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, "sw_dead");
    send(1, 0, 3'b010, 9'h010, 32'h0, "lw_dead");
    chk("lw_dead_lit", rd, 32'hDEADBEEF);

    send(0, 1, 3'b000, 9'h013, 32'h00000080, "sb_80");
    send(1, 0, 3'b000, 9'h013, 32'h0, "lb_80");
    chk("lb_80_lit", rd, 32'hFFFFFF80);
    send(1, 0, 3'b100, 9'h013, 32'h0, "lbu_80");
    chk("lbu_80_lit", rd, 32'h00000080);
    send(1, 0, 3'b010, 9'h010, 32'h0, "lw_80");
    chk("lw_80_lit", rd, 32'h80ADBEEF);
    send(1, 0, 3'b001, 9'h011, 32'h0, "lh_11");
    chk("lh_11_lit", rd, 32'hFFFFADBE);

    send(0, 1, 3'b010, 9'h1FE, 32'h11223344, "sw_wrap");
    if (SPLIT) begin
      send(1, 0, 3'b010, 9'h1FE, 32'h0, "lw_wrap");
      chk("lw_wrap_lit", rd, 32'h11223344);
      send(1, 0, 3'b100, 9'h000, 32'h0, "lbu_w0");
      chk("lbu_w0_lit", rd, 32'h00000022);
      send(1, 0, 3'b100, 9'h1FF, 32'h0, "lbu_1ff");
      chk("lbu_1ff_lit", rd, 32'h00000033);
    end
    send(1, 0, 3'b010, 9'h1FC, 32'h0, "lw_1fc");
    send(1, 0, 3'b010, 9'h000, 32'h0, "lw_000");

    send(1, 0, 3'b010, 9'h010, 32'h0, "pre_conf");
    send(1, 1, 3'b010, 9'h010, 32'h55555555, "conflict");
    chk("conflict_rd0", rd, 32'd0);
    send(1, 0, 3'b010, 9'h010, 32'h0, "post_conf");
    send(1, 0, 3'b011, 9'h014, 32'h0, "ld_f3_011");
    chk("ld_f3_011_rd0", rd, 32'd0);
    send(0, 1, 3'b100, 9'h014, 32'h12345678, "sb_f3_100");
    send(0, 1, 3'b011, 9'h018, 32'h12345678, "st_f3_011");
    send(1, 0, 3'b010, 9'h014, 32'h0, "lw_14");
    send(1, 0, 3'b010, 9'h018, 32'h0, "lw_18");
    send(0, 0, 3'b010, 9'h018, 32'h0, "noop");
    idle_cycle("after_noop");

`ifdef DM_MISALIGN_SPLIT_EN
    send(1, 0, 3'b010, 9'h010, 32'h0, "pre_rst");
    req_valid = 1'b1;
    MemWrite  = 1'b1;
    Funct3    = 3'b010;
    a         = 9'h0F2;
    wd        = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    MemWrite  = 1'b0;
    chk("b2rst_ready_lo", req_ready, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("b2rst_rv", rsp_valid, 32'd0);
    chk("b2rst_fault", fault, 32'd0);
    chk("b2rst_rd", rd, 32'd0);
    chk("b2rst_ready", req_ready, 32'd1);
    mm[9'h0F2] = 8'hDD;
    mm[9'h0F3] = 8'hCC;
    exp_rd = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("b2rst_ready_rel", req_ready, 32'd1);
    send(1, 0, 3'b010, 9'h0F0, 32'h0, "b2rst_w0");
    send(1, 0, 3'b010, 9'h0F4, 32'h0, "b2rst_w1");
`endif

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      mr = (r < 45) || (r >= 92);
      mw = (r >= 45 && r < 85) || (r >= 92);
      if ($urandom_range(0, 19) == 0) f3 = 3'($urandom);
      else if (mw) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      send(mr, mw, f3, 9'($urandom), $urandom, "rand");
      if ($urandom_range(0, 4) == 0) idle_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
